// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and trellis helpers for the 8-state, rate-1/2 code.
package viterbi_pkg;

  localparam int NUM_STATES = 8;
  localparam int STATE_W    = 3;
  localparam int BM_W       = 2;
  localparam int PM_W_DFLT  = 8;

  typedef logic [PM_W_DFLT-1:0] pm_t;

  // Shift-register trellis: next = {in_bit, s[2:1]}, so both predecessors share n[1:0].
  function automatic logic [STATE_W-1:0] pred0(input logic [STATE_W-1:0] n);
    return {n[1:0], 1'b0};
  endfunction

  function automatic logic [STATE_W-1:0] pred1(input logic [STATE_W-1:0] n);
    return {n[1:0], 1'b1};
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: two candidate metrics, keep the smaller (ties go to predecessor 0).
import viterbi_pkg::*;

module acs_cell #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  output logic [PM_W:0]   sum,
  output logic            dec
);

  logic [PM_W:0] c0;
  logic [PM_W:0] c1;

  assign c0  = {1'b0, pm_a} + {{(PM_W+1-BM_W){1'b0}}, bm_a};
  assign c1  = {1'b0, pm_b} + {{(PM_W+1-BM_W){1'b0}}, bm_b};
  assign dec = (c1 < c0);
  assign sum = dec ? c1 : c0;

endmodule

// File: rtl/acs_pm_bank.sv
// Eight-state ACS bank with path-metric registers, MSB normalisation, best-state search
// and a saturating symbol counter.
import viterbi_pkg::*;

module acs_pm_bank #(
  parameter int PM_W      = 8,
  parameter int INIT_BIAS = 16,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [NUM_STATES-1:0][BM_W-1:0]       bm0,
  input  logic [NUM_STATES-1:0][BM_W-1:0]       bm1,
  output logic                                  dec_valid,
  output logic [NUM_STATES-1:0]                 dec,
  output logic [STATE_W-1:0]                    best_state,
  output logic [NUM_STATES-1:0][PM_W-1:0]       pm,
  output logic                                  norm_pulse,
  output logic [CNT_W-1:0]                      sym_cnt
);

  logic [NUM_STATES-1:0][PM_W-1:0] pm_init;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_old;
  logic [NUM_STATES-1:0][PM_W:0]   sum;
  logic [NUM_STATES-1:0]           d;
  logic [NUM_STATES-1:0]           msb;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_new;
  logic                            norm;
  logic [STATE_W-1:0]              best;
  logic [PM_W-1:0]                 best_val;

  always_comb begin
    pm_init = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      pm_init[i] = PM_W'(INIT_BIAS);
    end
  end

  // A start pulse lets the same cycle's symbol run on fresh metrics.
  assign pm_old = start ? pm_init : pm;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    acs_cell #(.PM_W(PM_W)) u_acs (
      .pm_a (pm_old[pred0(STATE_W'(n))]),
      .pm_b (pm_old[pred1(STATE_W'(n))]),
      .bm_a (bm0[n]),
      .bm_b (bm1[n]),
      .sum  (sum[n]),
      .dec  (d[n])
    );
    assign msb[n] = sum[n][PM_W-1];
  end

  // Bounded spread keeps every metric inside PM_W bits, so dropping the shared MSB is exact.
  assign norm = &msb;

  always_comb begin
    pm_new = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_new[i] = sum[i][PM_W-1:0];
      if (norm) begin
        pm_new[i][PM_W-1] = 1'b0;
      end
    end
  end

  always_comb begin
    best     = '0;
    best_val = pm_new[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm_new[i] < best_val) begin
        best     = STATE_W'(i);
        best_val = pm_new[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm         <= pm_init;
      dec        <= '0;
      best_state <= '0;
      dec_valid  <= 1'b0;
      norm_pulse <= 1'b0;
      sym_cnt    <= '0;
    end else if (in_valid) begin
      pm         <= pm_new;
      dec        <= d;
      best_state <= best;
      dec_valid  <= 1'b1;
      norm_pulse <= norm;
      if (start) begin
        sym_cnt <= CNT_W'(1);
      end else if (sym_cnt != {CNT_W{1'b1}}) begin
        sym_cnt <= sym_cnt + CNT_W'(1);
      end
    end else begin
      dec_valid  <= 1'b0;
      norm_pulse <= 1'b0;
      if (start) begin
        pm      <= pm_init;
        sym_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_acs_pm_bank.sv
// Randomised bench for acs_pm_bank against an arithmetic trellis model, plus directed boundary cases.
module tb_acs_pm_bank;

  localparam int NS    = 8;
  localparam int PM_W  = 8;
  localparam int BIAS  = 16;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  in_valid;
  logic [NS-1:0][1:0]    bm0;
  logic [NS-1:0][1:0]    bm1;
  logic                  dec_valid;
  logic [NS-1:0]         dec;
  logic [2:0]            best_state;
  logic [NS-1:0][PM_W-1:0] pm;
  logic                  norm_pulse;
  logic [CNT_W-1:0]      sym_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_pm[NS];
  int m_dec, m_best, m_dv, m_norm, m_cnt;
  int norm_seen;

  acs_pm_bank #(.PM_W(PM_W), .INIT_BIAS(BIAS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .bm0        (bm0),
    .bm1        (bm1),
    .dec_valid  (dec_valid),
    .dec        (dec),
    .best_state (best_state),
    .pm         (pm),
    .norm_pulse (norm_pulse),
    .sym_cnt    (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_pm[i] = (i == 0) ? 0 : BIAS;
    m_dec = 0; m_best = 0; m_dv = 0; m_norm = 0; m_cnt = 0;
  endtask

  // Next-state of the model from the inputs currently being driven.
  task automatic model_step();
    int old[NS];
    int nw[NS];
    int c0, c1, p0, dd, all_hi;
    for (int i = 0; i < NS; i++) old[i] = start ? ((i == 0) ? 0 : BIAS) : m_pm[i];
    if (!in_valid) begin
      m_dv = 0; m_norm = 0;
      if (start) begin
        for (int i = 0; i < NS; i++) m_pm[i] = old[i];
        m_cnt = 0;
      end
      return;
    end
    dd = 0; all_hi = 1;
    for (int n = 0; n < NS; n++) begin
      p0 = (n % 4) * 2;
      c0 = old[p0] + int'(bm0[n]);
      c1 = old[p0 + 1] + int'(bm1[n]);
      if (c1 < c0) begin
        nw[n] = c1;
        dd = dd | (1 << n);
      end else begin
        nw[n] = c0;
      end
      if (nw[n] < 128) all_hi = 0;
    end
    for (int n = 0; n < NS; n++) m_pm[n] = all_hi ? nw[n] - 128 : nw[n];
    m_best = 0;
    for (int n = 1; n < NS; n++) if (m_pm[n] < m_pm[m_best]) m_best = n;
    m_dec = dd; m_dv = 1; m_norm = all_hi;
    m_cnt = start ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
  endtask

  function automatic logic [63:0] model_pm_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*8 +: 8] = m_pm[i][7:0];
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".pm"},   64'(pm),         model_pm_vec());
    check({tag, ".dec"},  64'(dec),        64'(m_dec));
    check({tag, ".best"}, 64'(best_state), 64'(m_best));
    check({tag, ".dv"},   64'(dec_valid),  64'(m_dv));
    check({tag, ".norm"}, 64'(norm_pulse), 64'(m_norm));
    check({tag, ".cnt"},  64'(sym_cnt),    64'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
    if (norm_pulse) norm_seen++;
  endtask

  task automatic drive(input logic s, input logic v, input int b0, input int b1);
    start = s; in_valid = v;
    for (int i = 0; i < NS; i++) begin
      bm0[i] = 2'(b0);
      bm1[i] = 2'(b1);
    end
  endtask

  task automatic drive_rand(input int p_start, input int p_valid);
    start    = ($urandom_range(99) < p_start);
    in_valid = ($urandom_range(99) < p_valid);
    for (int i = 0; i < NS; i++) begin
      bm0[i] = 2'($urandom_range(2));
      bm1[i] = 2'($urandom_range(2));
    end
  endtask

  initial begin
    norm_seen = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 0, 2);
    cycle("single");
    check("single.pm_const", 64'(pm), 64'h1010_1000_1010_1000);
    check("single.cnt_const", 64'(sym_cnt), 64'd1);

    // Equal-cost metrics everywhere: bm0 = bm1 must pick predecessor 0.
    drive(1'b0, 1'b1, 1, 1);
    for (int k = 0; k < 6; k++) cycle("tie");

    drive(1'b1, 1'b1, 2, 2);
    cycle("norm_start");
    drive(1'b0, 1'b1, 2, 2);
    for (int k = 0; k < 90; k++) cycle("norm_run");
    check("norm_seen", 64'(norm_seen > 0), 64'd1);

    drive(1'b0, 1'b0, 1, 2);
    for (int k = 0; k < 5; k++) cycle("hold");

    drive(1'b1, 1'b0, 0, 0);
    cycle("start_idle");

    drive(1'b0, 1'b1, 1, 0);
    for (int k = 0; k < 39; k++) cycle("pre_restart");
    drive(1'b1, 1'b1, 2, 0);
    cycle("restart");
    check("restart.pm_const",  64'(pm),      64'h1010_1002_1010_1002);
    check("restart.dec_const", 64'(dec),     64'hEE);
    check("restart.cnt_const", 64'(sym_cnt), 64'd1);

    drive(1'b0, 1'b1, 1, 1);
    for (int k = 0; k < CMAX + 5; k++) begin
      drive_rand(0, 100);
      cycle("saturate");
    end
    check("sat.cnt_const", 64'(sym_cnt), 64'(CMAX));

    for (int k = 0; k < 400; k++) begin
      drive_rand(5, 75);
      cycle("random");
    end

    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("mid_reset");
    @(negedge clk);
    drive_rand(0, 100);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive_rand(3, 80);
      cycle("post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
